// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture slice.
// Imported by the capture top and its bank RAM.
package scope_pkg;

   localparam int H_PIXELS = 640;
   localparam int SAMPLE_W = 8;
   localparam int COL_W    = 10;

   localparam logic [COL_W-1:0] RD_Y_NONE = 10'h3FF;

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      CAPTURE = 2'd1,
      FULL    = 2'd2
   } state_e;

endpackage

// File: rtl/scope_capture_if.sv
// Sample stream, control and display read bundle.
// master drives samples and columns; slave is the capture block.
interface scope_capture_if;
   import scope_pkg::*;

   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample_data;
   logic [SAMPLE_W-1:0] trig_level;
   logic [3:0]          decim;
   logic                freeze;
   logic                frame_start;
   logic [COL_W-1:0]    rd_col;
   logic [COL_W-1:0]    rd_y;
   logic                disp_valid;
   logic                trig_auto;

   modport master (
      output sample_valid, sample_data, trig_level, decim,
      output freeze, frame_start, rd_col,
      input  rd_y, disp_valid, trig_auto
   );

   modport slave (
      input  sample_valid, sample_data, trig_level, decim,
      input  freeze, frame_start, rd_col,
      output rd_y, disp_valid, trig_auto
   );

endinterface

// File: rtl/scope_bank_ram.sv
// Two-bank sample RAM, one sync write port and one sync read port.
// Indexed as {bank, col}; written as a plain array for BRAM inference.
module scope_bank_ram
   import scope_pkg::*;
(
   input  logic                clk,
   input  logic                wr_en,
   input  logic                wr_bank,
   input  logic [COL_W-1:0]    wr_col,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                rd_bank,
   input  logic [COL_W-1:0]    rd_col,
   output logic [SAMPLE_W-1:0] rd_data
);

   logic [SAMPLE_W-1:0] mem [0:1][0:H_PIXELS-1];

   always_ff @(posedge clk) begin
      if (wr_en && (wr_col < COL_W'(H_PIXELS)))
         mem[wr_bank][wr_col] <= wr_data;
   end

   // Out-of-range columns are masked downstream, so the read just holds.
   always_ff @(posedge clk) begin
      if (rd_col < COL_W'(H_PIXELS))
         rd_data <= mem[rd_bank][rd_col];
   end

endmodule

// File: rtl/scope_capture.sv
// Triggered ping-pong sample capture feeding the VGA waveform plot.
// Decimation, trigger, capture FSM and read mapping live here.
module scope_capture
   import scope_pkg::*;
#(
   parameter int Y_TOP        = 112,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic      clk,
   input  logic      rst_n,
   scope_capture_if.slave bus
);

   localparam int TW = $clog2(AUTO_TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(AUTO_TIMEOUT - 1);
   localparam logic [COL_W-1:0] W_LAST = COL_W'(H_PIXELS - 1);

   state_e              state_q, state_d;
   logic [3:0]          dcnt_q, dcnt_d;
   logic [3:0]          decim_q, decim_d;
   logic [SAMPLE_W-1:0] prev_q, prev_d;
   logic [TW-1:0]       tcnt_q, tcnt_d;
   logic [COL_W-1:0]    waddr_q, waddr_d;
   logic                auto_pend_q, auto_pend_d;
   logic                disp_bank_q, disp_bank_d;
   logic                disp_valid_q, disp_valid_d;
   logic                trig_auto_q, trig_auto_d;
   logic [COL_W-1:0]    rd_col_q;
   logic [COL_W-1:0]    rd_y_q, rd_y_d;

   logic [3:0]          decim_eff;
   logic                accept;
   logic                trig;
   logic                wr_en;
   logic [COL_W-1:0]    wr_col;
   logic [SAMPLE_W-1:0] ram_q;

   // A decim change is only picked up at the start of a period.
   assign decim_eff = (dcnt_q == 4'd0) ? bus.decim : decim_q;
   assign accept = bus.sample_valid && (dcnt_q == decim_eff);
   assign trig = accept
              && (prev_q < bus.trig_level)
              && (bus.sample_data >= bus.trig_level);

   always_comb begin
      state_d      = state_q;
      dcnt_d       = dcnt_q;
      decim_d      = decim_q;
      prev_d       = prev_q;
      tcnt_d       = tcnt_q;
      waddr_d      = waddr_q;
      auto_pend_d  = auto_pend_q;
      disp_bank_d  = disp_bank_q;
      disp_valid_d = disp_valid_q;
      trig_auto_d  = trig_auto_q;
      wr_en        = 1'b0;
      wr_col       = waddr_q;

      if (bus.sample_valid) begin
         dcnt_d = accept ? 4'd0 : dcnt_q + 4'd1;
         if (dcnt_q == 4'd0)
            decim_d = bus.decim;
      end
      if (accept)
         prev_d = bus.sample_data;

      unique case (state_q)
         ARMED: begin
            if (accept) begin
               if (trig || (tcnt_q == T_LAST)) begin
                  wr_en       = 1'b1;
                  wr_col      = '0;
                  waddr_d     = COL_W'(1);
                  auto_pend_d = !trig;
                  state_d     = CAPTURE;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         CAPTURE: begin
            if (accept) begin
               wr_en = 1'b1;
               if (waddr_q == W_LAST)
                  state_d = FULL;
               else
                  waddr_d = waddr_q + COL_W'(1);
            end
         end
         FULL: begin
            if (bus.frame_start && !bus.freeze) begin
               disp_bank_d  = !disp_bank_q;
               disp_valid_d = 1'b1;
               trig_auto_d  = auto_pend_q;
               waddr_d      = '0;
               tcnt_d       = '0;
               state_d      = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   always_comb begin
      rd_y_d = RD_Y_NONE;
      if ((rd_col_q < COL_W'(H_PIXELS)) && disp_valid_q)
         rd_y_d = COL_W'(Y_TOP) + {2'b00, ~ram_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARMED;
         dcnt_q       <= '0;
         decim_q      <= '0;
         prev_q       <= 8'hFF;
         tcnt_q       <= '0;
         waddr_q      <= '0;
         auto_pend_q  <= 1'b0;
         disp_bank_q  <= 1'b0;
         disp_valid_q <= 1'b0;
         trig_auto_q  <= 1'b0;
         rd_col_q     <= '0;
         rd_y_q       <= RD_Y_NONE;
      end else begin
         state_q      <= state_d;
         dcnt_q       <= dcnt_d;
         decim_q      <= decim_d;
         prev_q       <= prev_d;
         tcnt_q       <= tcnt_d;
         waddr_q      <= waddr_d;
         auto_pend_q  <= auto_pend_d;
         disp_bank_q  <= disp_bank_d;
         disp_valid_q <= disp_valid_d;
         trig_auto_q  <= trig_auto_d;
         rd_col_q     <= bus.rd_col;
         rd_y_q       <= rd_y_d;
      end
   end

   scope_bank_ram u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_bank (!disp_bank_q),
      .wr_col  (wr_col),
      .wr_data (bus.sample_data),
      .rd_bank (disp_bank_q),
      .rd_col  (bus.rd_col),
      .rd_data (ram_q)
   );

   assign bus.rd_y       = rd_y_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.trig_auto  = trig_auto_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: trigger, decimation, timeout,
// freeze, mid-capture frame, out-of-range column and reset.
module tb_scope_capture;
   import scope_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #20 clk = ~clk;

   scope_capture_if bus ();

   scope_capture dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vecs = 0;
   int errs = 0;
   logic [7:0] ramp = 8'd0;
   logic       cmode = 1'b0;
   logic [7:0] cval = 8'd0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.sample_data = cmode ? cval : ramp;
      ramp = ramp + 8'd1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         drive();
      end
   endtask

   task automatic pulse();
      @(negedge clk);
      bus.frame_start = 1'b1;
      drive();
      @(negedge clk);
      bus.frame_start = 1'b0;
      drive();
   endtask

   task automatic rd(input logic [9:0] col, input logic [9:0] exp,
                     input string tag);
      @(negedge clk);
      bus.rd_col = col;
      drive();
      run(2);
      chk(tag, 32'(bus.rd_y), 32'(exp));
   endtask

   task automatic do_reset(input logic [7:0] start);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      ramp = start;
      drive();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = 8'd0;
      bus.trig_level   = 8'd128;
      bus.decim        = 4'd0;
      bus.freeze       = 1'b0;
      bus.frame_start  = 1'b0;
      bus.rd_col       = 10'd0;

      // reset state
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_rd_y", 32'(bus.rd_y), 32'h3FF);
      chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
      chk("rst_trig_auto", 32'(bus.trig_auto), 32'd0);

      // ramp, normal trigger on 128
      do_reset(8'd0);
      run(2000);
      chk("ramp_full", 32'(dut.state_q), 32'(FULL));
      chk("ramp_pre_valid", 32'(bus.disp_valid), 32'd0);
      pulse();
      chk("ramp_valid", 32'(bus.disp_valid), 32'd1);
      chk("ramp_auto", 32'(bus.trig_auto), 32'd0);
      rd(10'd0, 10'd239, "ramp_col0");
      rd(10'd1, 10'd238, "ramp_col1");
      rd(10'd639, 10'd112, "ramp_col639");
      rd(10'd640, 10'h3FF, "col640_none");

      // decimation by 4
      bus.decim = 4'd3;
      do_reset(8'd1);
      run(3000);
      pulse();
      chk("dec_valid", 32'(bus.disp_valid), 32'd1);
      rd(10'd0, 10'd239, "dec_col0");
      rd(10'd1, 10'd235, "dec_col1");
      rd(10'd2, 10'd231, "dec_col2");

      // auto timeout on a flat signal
      bus.decim = 4'd0;
      cmode = 1'b1;
      cval = 8'd50;
      do_reset(8'd0);
      run(4900);
      chk("auto_full", 32'(dut.state_q), 32'(FULL));
      chk("auto_pre_valid", 32'(bus.disp_valid), 32'd0);
      pulse();
      chk("auto_valid", 32'(bus.disp_valid), 32'd1);
      chk("auto_flag", 32'(bus.trig_auto), 32'd1);
      rd(10'd0, 10'd317, "auto_col0");
      rd(10'd320, 10'd317, "auto_col320");
      rd(10'd639, 10'd317, "auto_col639");

      // freeze holds the display through frame pulses
      cmode = 1'b0;
      ramp = 8'd0;
      run(1000);
      chk("frz_full", 32'(dut.state_q), 32'(FULL));
      bus.freeze = 1'b1;
      repeat (3) begin
         pulse();
         run(50);
      end
      chk("frz_bank", 32'(dut.disp_bank_q), 32'd1);
      chk("frz_auto", 32'(bus.trig_auto), 32'd1);
      rd(10'd0, 10'd317, "frz_col0");
      bus.freeze = 1'b0;
      pulse();
      chk("unfrz_auto", 32'(bus.trig_auto), 32'd0);
      chk("unfrz_bank", 32'(dut.disp_bank_q), 32'd0);
      rd(10'd0, 10'd239, "unfrz_col0");

      // frame pulse during capture is ignored
      run(300);
      chk("cap_state", 32'(dut.state_q), 32'(CAPTURE));
      pulse();
      chk("cap_hold_state", 32'(dut.state_q), 32'(CAPTURE));
      chk("cap_hold_bank", 32'(dut.disp_bank_q), 32'd0);
      rd(10'd1, 10'd238, "cap_hold_col1");

      // reset mid-capture
      chk("pre_rst_state", 32'(dut.state_q), 32'(CAPTURE));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.disp_valid), 32'd0);
      chk("mid_rst_rd_y", 32'(bus.rd_y), 32'h3FF);
      repeat (2) @(negedge clk);
      drive();
      rst_n = 1'b1;
      #1;
      chk("post_rst_state", 32'(dut.state_q), 32'(ARMED));
      chk("post_rst_waddr", 32'(dut.waddr_q), 32'd0);
      run(4);
      chk("post_rst_rd_y", 32'(bus.rd_y), 32'h3FF);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
